// File: rtl/ram32x8_arbiter.sv
// Round-robin arbiter/sequencer: two single-word requesters onto one 32x8 RAM port.
// Latency: req sampled at edge N -> ram_en in cycle N+1 -> ack/rdata in cycle N+2; one txn per 3 cycles.
// Backpressure: a requester holds req/fields until its ack; requests arriving while busy wait in IDLE.
module ram32x8_arbiter #(
  parameter int AW = 5,
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req0,
  input  logic          req1,
  input  logic          we0,
  input  logic          we1,
  input  logic [AW-1:0] addr0,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata0,
  input  logic [DW-1:0] wdata1,
  output logic          ack0,
  output logic          ack1,
  output logic [DW-1:0] rdata,
  output logic          busy,
  output logic          ram_en,
  output logic          ram_we,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_din,
  input  logic [DW-1:0] ram_dout
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t state, state_nxt;
  logic   gnt, gnt_nxt;   // index of the requester owning the current transaction
  logic   last;           // most recent grant; the other requester wins the next tie
  logic   grant;

  assign grant = (state == IDLE) && (req0 || req1);

  // Next-state and arbitration decision; only IDLE looks at the requests.
  always_comb begin
    state_nxt = state;
    gnt_nxt   = gnt;
    case (state)
      IDLE: begin
        if (req0 || req1) begin
          state_nxt = ACCESS;
          if (req0 && req1) gnt_nxt = ~last;
          else              gnt_nxt = req1;
        end
      end
      ACCESS:  state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State, current owner and round-robin history.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      gnt   <= 1'b0;
      last  <= 1'b1;
    end else begin
      state <= state_nxt;
      gnt   <= gnt_nxt;
      if (grant) last <= gnt_nxt;
    end
  end

  // Registered RAM drive, read capture and acknowledge pulses; every output is a flop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ram_en   <= 1'b0;
      ram_we   <= 1'b0;
      ram_addr <= '0;
      ram_din  <= '0;
      rdata    <= '0;
      ack0     <= 1'b0;
      ack1     <= 1'b0;
      busy     <= 1'b0;
    end else begin
      busy <= (state_nxt != IDLE);
      case (state)
        IDLE: begin
          if (grant) begin
            ram_en   <= 1'b1;
            ram_we   <= gnt_nxt ? we1    : we0;
            ram_addr <= gnt_nxt ? addr1  : addr0;
            ram_din  <= gnt_nxt ? wdata1 : wdata0;
          end
        end
        ACCESS: begin
          // The write (if any) commits in the RAM on this same edge.
          ram_en <= 1'b0;
          ram_we <= 1'b0;
          if (!ram_we) rdata <= ram_dout;
          if (gnt) ack1 <= 1'b1;
          else     ack0 <= 1'b1;
        end
        RESP: begin
          ack0 <= 1'b0;
          ack1 <= 1'b0;
        end
        default: begin
          ack0 <= 1'b0;
          ack1 <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ram32x8_arbiter.sv
module tb_ram32x8_arbiter;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       req0 = 1'b0, req1 = 1'b0, we0 = 1'b0, we1 = 1'b0;
  logic [4:0] addr0 = '0, addr1 = '0;
  logic [7:0] wdata0 = '0, wdata1 = '0;
  logic       ack0, ack1, busy, ram_en, ram_we;
  logic [4:0] ram_addr;
  logic [7:0] ram_din, ram_dout, rdata;

  logic [7:0] mem [32];
  logic       ram_init = 1'b1;
  int         checks = 0;
  int         errors = 0;

  always #5 clk = ~clk;

  ram32x8_arbiter #(.AW(5), .DW(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .ack0(ack0), .ack1(ack1), .rdata(rdata), .busy(busy),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_din(ram_din),
    .ram_dout(ram_dout)
  );

  function automatic logic [7:0] pat(input int i);
    return 8'(i * 37 + 11);
  endfunction

  // Behavioural 32x8 RAM attached to the arbiter.
  always @(posedge clk) begin
    if (ram_init) begin
      for (int i = 0; i < 32; i++) mem[i] <= pat(i);
    end else if (ram_en && ram_we) begin
      mem[ram_addr] <= ram_din;
    end
  end
  assign ram_dout = mem[ram_addr];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- transaction-level reference model ----------------
  typedef struct packed {
    logic       en;
    logic       we;
    logic [4:0] addr;
    logic [7:0] din;
    logic       a0;
    logic       a1;
    logic [7:0] rd;
    logic       busy;
  } obs_t;

  obs_t       q[$];
  obs_t       cur;
  logic       cur_idle;
  logic       m_last;
  logic [4:0] m_addr;
  logic [7:0] m_din, m_rdata;
  logic [7:0] model_mem [32];

  function automatic obs_t actual();
    return '{ram_en, ram_we, ram_addr, ram_din, ack0, ack1, rdata, busy};
  endfunction

  // Called right after each rising edge: decides what the next cycle must look like.
  task automatic model_step();
    logic       w, g_we;
    logic [4:0] g_addr;
    logic [7:0] g_din, old;
    if (cur_idle && (req0 || req1)) begin
      w      = (req0 && req1) ? ~m_last : req1;
      m_last = w;
      g_we   = w ? we1 : we0;
      g_addr = w ? addr1 : addr0;
      g_din  = w ? wdata1 : wdata0;
      old    = m_rdata;
      if (g_we) model_mem[g_addr] = g_din;
      else      m_rdata = model_mem[g_addr];
      m_addr = g_addr;
      m_din  = g_din;
      q.push_back('{1'b1, g_we, g_addr, g_din, 1'b0, 1'b0, old, 1'b1});
      q.push_back('{1'b0, 1'b0, g_addr, g_din, ~w, w, m_rdata, 1'b1});
    end
    if (q.size() > 0) begin
      cur      = q.pop_front();
      cur_idle = 1'b0;
    end else begin
      cur      = '{1'b0, 1'b0, m_addr, m_din, 1'b0, 1'b0, m_rdata, 1'b0};
      cur_idle = 1'b1;
    end
  endtask

  // ---------------- helpers ----------------
  typedef struct {
    logic       who;
    logic       we;
    logic [4:0] addr;
    logic [7:0] wdata;
    logic [7:0] exp_rd;
  } vec_t;

  task automatic do_reset();
    rst_n = 1'b0;
    req0  = 1'b0;
    req1  = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Starts at a negedge with the DUT idle; ends at a negedge with the DUT idle.
  task automatic run_single(input vec_t v);
    if (v.who) begin
      req1 = 1'b1; we1 = v.we; addr1 = v.addr; wdata1 = v.wdata;
    end else begin
      req0 = 1'b1; we0 = v.we; addr0 = v.addr; wdata0 = v.wdata;
    end
    @(negedge clk);
    check("single_access", {ram_en, ram_we, ram_addr, ram_din, busy, ack0, ack1},
          {1'b1, v.we, v.addr, v.wdata, 1'b1, 1'b0, 1'b0});
    @(negedge clk);
    check("single_resp", {ram_en, ram_we, ack0, ack1, rdata, busy},
          {1'b0, 1'b0, ~v.who, v.who, v.exp_rd, 1'b1});
    req0 = 1'b0;
    req1 = 1'b0;
    @(negedge clk);
    check("single_idle", {ram_en, ack0, ack1, busy}, 4'b0000);
  endtask

  vec_t       vecs [7];
  logic [7:0] old7;
  logic       pend0, pend1;
  logic       e0, e1, een;

  initial begin
    vecs[0] = '{1'b0, 1'b1, 5'd31, 8'hA5, 8'h00};
    vecs[1] = '{1'b0, 1'b0, 5'd31, 8'h00, 8'hA5};
    vecs[2] = '{1'b1, 1'b1, 5'd0,  8'h5A, 8'hA5};
    vecs[3] = '{1'b1, 1'b0, 5'd0,  8'h77, 8'h5A};
    vecs[4] = '{1'b0, 1'b1, 5'd16, 8'hC3, 8'h5A};
    vecs[5] = '{1'b1, 1'b0, 5'd16, 8'h12, 8'hC3};
    vecs[6] = '{1'b0, 1'b0, 5'd31, 8'h34, 8'hA5};

    // Reset held with both requesters active: everything stays at zero.
    req0 = 1'b1; we0 = 1'b0; addr0 = 5'd4; wdata0 = 8'h00;
    req1 = 1'b1; we1 = 1'b0; addr1 = 5'd9; wdata1 = 8'h00;
    repeat (3) @(negedge clk);
    ram_init = 1'b0;
    @(negedge clk);
    check("reset_outputs", 32'(actual()), 32'h0);

    // Release with a tie pending: grants 0,1,0,1, acks one cycle wide, 3 cycles apart.
    rst_n = 1'b1;
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      e0  = (i % 3 == 2) && ((i / 3) % 2 == 0);
      e1  = (i % 3 == 2) && ((i / 3) % 2 == 1);
      een = (i % 3 == 1) && (i < 12);
      check("tie_ack_en", {ack0, ack1, ram_en}, {e0, e1, een});
      if (i == 1) check("tie_first_addr", ram_addr, 5'd4);
      if (i == 2) check("tie_rdata0", rdata, pat(4));
      if (i == 5) check("tie_rdata1", rdata, pat(9));
      if (i == 11) begin
        req0 = 1'b0;
        req1 = 1'b0;
      end
    end

    // Randomized traffic against the reference model.
    do_reset();
    m_last = 1'b1; m_addr = '0; m_din = '0; m_rdata = '0; cur_idle = 1'b1;
    for (int i = 0; i < 32; i++) model_mem[i] = pat(i);
    pend0 = 1'b0;
    pend1 = 1'b0;
    for (int c = 0; c < 612; c++) begin
      @(posedge clk);
      model_step();
      @(negedge clk);
      check("random_cycle", 32'(actual()), 32'(cur));
      if (cur.a0) pend0 = 1'b0;
      if (cur.a1) pend1 = 1'b0;
      if (!pend0) begin
        if (c < 600 && $urandom_range(0, 2) != 0) begin
          pend0 = 1'b1; req0 = 1'b1; we0 = 1'($urandom);
          addr0 = ($urandom_range(0, 3) == 0) ? ($urandom_range(0, 1) ? 5'd31 : 5'd0) : 5'($urandom);
          wdata0 = 8'($urandom);
        end else req0 = 1'b0;
      end
      if (!pend1) begin
        if (c < 600 && $urandom_range(0, 2) != 0) begin
          pend1 = 1'b1; req1 = 1'b1; we1 = 1'($urandom);
          addr1 = ($urandom_range(0, 3) == 0) ? ($urandom_range(0, 1) ? 5'd31 : 5'd0) : 5'($urandom);
          wdata1 = 8'($urandom);
        end else req1 = 1'b0;
      end
    end
    for (int i = 0; i < 32; i++) check("random_mem", mem[i], model_mem[i]);

    // Table-driven single transactions from a fresh reset (rdata starts at 0).
    do_reset();
    for (int k = 0; k < 7; k++) run_single(vecs[k]);

    // Requester 1 changes its fields and drops req during ACCESS.
    old7 = mem[7];
    req1 = 1'b1; we1 = 1'b1; addr1 = 5'd3; wdata1 = 8'h3C;
    @(negedge clk);
    addr1 = 5'd7; wdata1 = 8'hFF; req1 = 1'b0;
    check("chg_captured", {ram_en, ram_we, ram_addr, ram_din}, {1'b1, 1'b1, 5'd3, 8'h3C});
    @(negedge clk);
    check("chg_ack", {ack0, ack1, rdata}, {1'b0, 1'b1, 8'hA5});
    @(negedge clk);
    check("chg_mem3", mem[3], 8'h3C);
    check("chg_mem7", mem[7], old7);

    // Reset falling inside ACCESS aborts the write and suppresses the ack.
    run_single('{1'b0, 1'b1, 5'd10, 8'h11, 8'hA5});
    req0 = 1'b1; we0 = 1'b1; addr0 = 5'd10; wdata0 = 8'h55;
    @(negedge clk);
    check("abort_en_before", ram_en, 1'b1);
    #2 rst_n = 1'b0;
    #1 check("abort_en_async", {ram_en, ram_we, busy}, 3'b000);
    req0 = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("abort_no_ack", {ack0, ack1, busy}, 3'b000);
    end
    check("abort_mem10", mem[10], 8'h11);
    run_single('{1'b0, 1'b0, 5'd10, 8'h00, 8'h11});

    // Lone requester 1 back-to-back, then req0 arrives together with req1 and wins.
    do_reset();
    req1 = 1'b1; we1 = 1'b0; addr1 = 5'd3; wdata1 = 8'h00;
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      e0  = (i == 8);
      e1  = (i == 2) || (i == 5) || (i == 11);
      een = (i % 3 == 1) && (i < 12);
      check("lone_ack_en", {ack0, ack1, ram_en}, {e0, e1, een});
      if (i == 2) begin
        check("lone_rd1", rdata, 8'h3C);
        addr1 = 5'd10;
      end
      if (i == 5) begin
        check("lone_rd2", rdata, 8'h11);
        addr1 = 5'd3;
        req0 = 1'b1; we0 = 1'b0; addr0 = 5'd10;
      end
      if (i == 8) begin
        check("lone_rd_req0", rdata, 8'h11);
        req0 = 1'b0;
      end
      if (i == 11) begin
        check("lone_rd3", rdata, 8'h3C);
        req1 = 1'b0;
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
